// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
//
// Purpose: takes a raster-order pixel stream. It keeps two line buffers and a
// 3x3 sliding window. For every complete window, it presents the window and
// the 3x3 kernel to nine external multipliers. It then waits for the
// accumulated result before taking more pixels.
//
// Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready
// are both 1. pix_valid may rise and fall freely. pix_ready is 1 only in FILL.
// After a transfer, the pixel is consumed and the source may present the next
// one in the same cycle.
//
// Ports:
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   k_load/k_addr/k_data kernel weight write port (index 0..8)
//   pix_valid/pix_data  pixel stream in, pix_ready back-pressure out
//   multiplier_input    flat 3x3 pixel window, element r*3+c at [i*DW +: DW]
//   multiplicand_input  flat 3x3 kernel, same element layout
//   mStart              one-cycle start pulse to all nine multipliers
//   cReady              accumulated result done (sampled only in WAIT)
//   win_x, win_y        output coordinate of the issued window
//   frame_done          one-cycle pulse after the last window of a frame
//   dbg_state           current FSM state, for observation only
// ---------------------------------------------------------------------------
module conv_window_feeder #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          k_load,
    input  logic [3:0]                    k_addr,
    input  logic [DATA_WIDTH-1:0]         k_data,
    input  logic                          pix_valid,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          pix_ready,
    output logic [9*DATA_WIDTH-1:0]       multiplier_input,
    output logic [9*DATA_WIDTH-1:0]       multiplicand_input,
    output logic [8:0]                    mStart,
    input  logic                          cReady,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
    output logic                          frame_done,
    output logic [2:0]                    dbg_state
);

    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);
    localparam int NTAP = KERNEL_SIZE * KERNEL_SIZE;

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         col_q, col_d;
    logic [YW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];   // row-2 (oldest) line
    logic [DATA_WIDTH-1:0] lb0_d [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];   // row-1 line
    logic [DATA_WIDTH-1:0] lb1_d [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win_q [NTAP];
    logic [DATA_WIDTH-1:0] win_d [NTAP];
    logic [DATA_WIDTH-1:0] kern_q [NTAP];
    logic [DATA_WIDTH-1:0] kern_d [NTAP];
    logic [XW-1:0]         win_x_q, win_x_d;
    logic [YW-1:0]         win_y_q, win_y_d;
    logic                  last_q, last_d;      // issued window closes the frame
    logic                  pix_ready_q, pix_ready_d;
    logic [8:0]            mstart_q, mstart_d;
    logic                  frame_done_q, frame_done_d;

    logic accept;
    logic k_write;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lb0_d    = lb0_q;
        lb1_d    = lb1_q;
        win_d    = win_q;
        kern_d   = kern_q;
        win_x_d  = win_x_q;
        win_y_d  = win_y_q;
        last_d   = last_q;

        accept  = pix_valid && pix_ready_q;
        // Kernel is frozen while a window is in flight in the multipliers.
        k_write = k_load && (k_addr <= 4'd8) &&
                  ((state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DONE));
        if (k_write) begin
            kern_d[k_addr] = k_data;
        end

        case (state_q)
            S_IDLE: state_d = S_FILL;
            S_FILL: begin
                if (accept) begin
                    // Column shift: each row moves left, the new column enters at c=2
                    // taken from (oldest line, previous line, incoming pixel).
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    win_d[2] = lb0_q[col_q];
                    win_d[3] = win_q[4];
                    win_d[4] = win_q[5];
                    win_d[5] = lb1_q[col_q];
                    win_d[6] = win_q[7];
                    win_d[7] = win_q[8];
                    win_d[8] = pix_data;
                    lb0_d[col_q] = lb1_q[col_q];
                    lb1_d[col_q] = pix_data;

                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
                    end else begin
                        col_d = col_q + XW'(1);
                    end

                    if ((col_q >= XW'(2)) && (row_q >= YW'(2))) begin
                        state_d = S_ISSUE;
                        win_x_d = col_q - XW'(2);
                        win_y_d = row_q - YW'(2);
                        last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (cReady) begin
                    state_d = last_q ? S_DONE : S_FILL;
                end
            end
            S_DONE:  state_d = S_FILL;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        pix_ready_d  = (state_d == S_FILL);
        mstart_d     = (state_d == S_ISSUE) ? 9'h1FF : 9'h000;
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            lb0_q        <= '{default: '0};
            lb1_q        <= '{default: '0};
            win_q        <= '{default: '0};
            kern_q       <= '{default: '0};
            win_x_q      <= '0;
            win_y_q      <= '0;
            last_q       <= 1'b0;
            pix_ready_q  <= 1'b0;
            mstart_q     <= 9'h000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            lb0_q        <= lb0_d;
            lb1_q        <= lb1_d;
            win_q        <= win_d;
            kern_q       <= kern_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            last_q       <= last_d;
            pix_ready_q  <= pix_ready_d;
            mstart_q     <= mstart_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_flat
        assign multiplier_input[i*DATA_WIDTH +: DATA_WIDTH]   = win_q[i];
        assign multiplicand_input[i*DATA_WIDTH +: DATA_WIDTH] = kern_q[i];
    end

    assign pix_ready  = pix_ready_q;
    assign mStart     = mstart_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule
